fpu_seq: RTL and testbench
==========================

# fpu_seq

Command sequencer that drives the fpu block's control pins on behalf of a host. It accepts store and compute commands over a valid/ready handshake and runs the fpu's enable/ld/address protocol. It waits for the fpu's done and returns the result word plus exception and compare flags on a response channel. It sits between the host bus and fpu; fpu_done is the only completion signal it trusts, guarded by a watchdog.

## Interface
- TIMEOUT, 64: max EXEC cycles waiting for fpu_done before abort.
- SCRATCH_ADDR, 31: SRAM word sacrificed by the SYNC write; software never stores operands there.
- clk  in  1  sole clock, rising edge.
- rstp  in  1  reset, asynchronous, active-low.
- cmd_valid / cmd_ready  in / out  1  command handshake; transfer when both high.
- cmd_kind  in  1  0 = compute, 1 = store.
- cmd_op  in  3  fpu opcode: 0 add, 1 mul, 2 div, 3 sqrt, 4 compare.
- cmd_round  in  3  rounding mode.
- cmd_src1, cmd_src2, cmd_dst  in  5  SRAM addresses.
- cmd_data  in  32  store data.
- rsp_valid / rsp_ready  out / in  1  response handshake.
- rsp_data  out  32  result: fpu_out for compute, cmd_data echo for store.
- rsp_flags  out  9  {timeout, ov, un, inv, inexact, div_zero, less, eq, great}.
- fpu_inp  out  32  to fpu inp.
- fpu_addr1, fpu_addr2, fpu_addr3  out  5  to fpu addresses.
- fpu_opcode, fpu_round  out  3  to fpu opcode_in, round_mp.
- fpu_enable, fpu_ld  out  1  to fpu enable, ld.
- fpu_out  in  32; fpu_done, fpu_ov, fpu_un, fpu_inv, fpu_inexact, fpu_div_zero, fpu_less, fpu_eq, fpu_great  in  1 each.

## Operation
- All outputs registered. Reset: state IDLE, fpu_enable=1, fpu_ld=1, all other outputs 0, cmd_ready=1, rsp_valid=0.
- Safe pattern (IDLE, RESP): fpu_enable=1, fpu_ld=1. The fpu performs no SRAM write; periodic fpu_done pulses are ignored.
- IDLE: cmd_ready=1. On accept, latch the command, then go to STORE (kind 1) or SYNC (kind 0).
- STORE, 1 cycle: enable=0, ld=0, addr1=dst, inp=data. The fpu writes data to dst. Then RESP with flags 0.
- SYNC, 1 cycle: enable=0, ld=0, addr1=SCRATCH_ADDR, inp=0. This clears the fpu done counter. fpu_opcode/fpu_round are set to the command and held until RESP.
- LOAD, 1 cycle: enable=1, ld=1, addr1=src1, addr2=src2. The fpu operand registers load.
- EXEC: enable=1, ld=0, addr3=dst, watchdog counting. In the cycle fpu_done=1, the fpu writes to dst; that same cycle, capture fpu_out and all flags into the response. Then RESP.
- EXEC watchdog reaching TIMEOUT: rsp_data=0, flags={1, 8'b0}, then RESP. No write was issued.
- RESP: rsp_valid=1, safe pattern, cmd_ready=0. Exit to IDLE on rsp_ready; the next command can be accepted the following cycle.
- A compare (op 4) returns fpu_out as sampled (0). less/eq/great are captured verbatim.
- Reset asserted mid-command aborts it immediately to reset values. No response is produced.

## Timing
- Store: accept at edge N; the write happens in cycle N+1; rsp_valid rises at N+2.
- Compute: SYNC at N+1, LOAD at N+2, EXEC from N+3. add/mul done arrives 2 EXEC cycles later, div/sqrt 7, compare 1. rsp_valid rises the edge after done.
- Watchdog: counts EXEC cycles from 1. Abort when count == TIMEOUT with no done seen; done on that same cycle wins.
- rsp_* stable while rsp_valid && !rsp_ready.

## Structure
- Shared package fpu_pkg: opcode constants (OP_ADD..OP_CMP), state enum (IDLE, STORE, SYNC, LOAD, EXEC, RESP), flag bit indices, command struct.
- Single module; the watchdog counter is inline ($clog2(TIMEOUT+1) bits). No sub-module.

## Test plan
- Store 0x3F800000 to addr 2 → fpu_enable=0, addr1=2, inp=0x3F800000 for exactly 1 cycle; rsp_data=0x3F800000, flags=0.
- Compute add src1=2 (1.0), src2=3 (2.0), dst=4, against the real fpu → rsp_data=0x40400000. addr4 reads 0x40400000; addr2/3 unchanged.
- Div 1.0/0.0 → div_zero=1 in rsp_flags; rsp_valid 10 cycles after accept.
- Compare 1.0 vs 2.0 → the captured less/eq/great match the fpu pins at done.
- Stub fpu with done stuck at 0 → timeout flag set after exactly TIMEOUT EXEC cycles; no write enable (enable=0) seen in EXEC.
- rsp_ready held low 5 cycles → response stable, cmd_ready=0, enable/ld both 1 throughout. Reset pulse during EXEC → outputs at reset values on the next cycle, and no response.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared definitions for the fpu command sequencer: opcodes, FSM states,
// response flag bit positions and the latched command record.
package fpu_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_MUL  = 3'd1;
    localparam logic [2:0] OP_DIV  = 3'd2;
    localparam logic [2:0] OP_SQRT = 3'd3;
    localparam logic [2:0] OP_CMP  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        STORE = 3'd1,
        SYNC  = 3'd2,
        LOAD  = 3'd3,
        EXEC  = 3'd4,
        RESP  = 3'd5
    } state_t;

    // Bit positions inside rsp_flags.
    localparam int FLG_GREAT    = 0;
    localparam int FLG_EQ       = 1;
    localparam int FLG_LESS     = 2;
    localparam int FLG_DIV_ZERO = 3;
    localparam int FLG_INEXACT  = 4;
    localparam int FLG_INV      = 5;
    localparam int FLG_UN       = 6;
    localparam int FLG_OV       = 7;
    localparam int FLG_TIMEOUT  = 8;

    typedef struct packed {
        logic [2:0]  op;
        logic [2:0]  round;
        logic [4:0]  src1;
        logic [4:0]  src2;
        logic [4:0]  dst;
        logic [31:0] data;
    } cmd_t;

endpackage

// File: rtl/fpu_seq.sv
// Host-side sequencer for the fpu: turns store/compute commands into the
// fpu enable/ld/address protocol and returns result words with flags.
module fpu_seq
    import fpu_pkg::*;
#(
    parameter int          TIMEOUT      = 64,
    parameter logic [4:0]  SCRATCH_ADDR = 5'd31
) (
    input  logic        clk,
    input  logic        rstp,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_kind,
    input  logic [2:0]  cmd_op,
    input  logic [2:0]  cmd_round,
    input  logic [4:0]  cmd_src1,
    input  logic [4:0]  cmd_src2,
    input  logic [4:0]  cmd_dst,
    input  logic [31:0] cmd_data,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [8:0]  rsp_flags,

    output logic [31:0] fpu_inp,
    output logic [4:0]  fpu_addr1,
    output logic [4:0]  fpu_addr2,
    output logic [4:0]  fpu_addr3,
    output logic [2:0]  fpu_opcode,
    output logic [2:0]  fpu_round,
    output logic        fpu_enable,
    output logic        fpu_ld,

    input  logic [31:0] fpu_out,
    input  logic        fpu_done,
    input  logic        fpu_ov,
    input  logic        fpu_un,
    input  logic        fpu_inv,
    input  logic        fpu_inexact,
    input  logic        fpu_div_zero,
    input  logic        fpu_less,
    input  logic        fpu_eq,
    input  logic        fpu_great
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_t            state_reg;
    cmd_t              cmd_reg;
    logic [WD_W-1:0]   wd_reg;

    always_ff @(posedge clk or negedge rstp) begin
        if (!rstp) begin
            state_reg  <= IDLE;
            cmd_reg    <= '0;
            wd_reg     <= '0;
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_flags  <= '0;
            fpu_inp    <= '0;
            fpu_addr1  <= '0;
            fpu_addr2  <= '0;
            fpu_addr3  <= '0;
            fpu_opcode <= '0;
            fpu_round  <= '0;
            fpu_enable <= 1'b1;
            fpu_ld     <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_reg    <= '{op: cmd_op, round: cmd_round, src1: cmd_src1,
                                        src2: cmd_src2, dst: cmd_dst, data: cmd_data};
                        cmd_ready  <= 1'b0;
                        fpu_enable <= 1'b0;
                        fpu_ld     <= 1'b0;
                        if (cmd_kind) begin
                            fpu_addr1 <= cmd_dst;
                            fpu_inp   <= cmd_data;
                            state_reg <= STORE;
                        end else begin
                            // Dummy write to the scratch word resets the fpu done counter.
                            fpu_addr1  <= SCRATCH_ADDR;
                            fpu_inp    <= '0;
                            fpu_opcode <= cmd_op;
                            fpu_round  <= cmd_round;
                            state_reg  <= SYNC;
                        end
                    end
                end

                STORE: begin
                    fpu_enable <= 1'b1;
                    fpu_ld     <= 1'b1;
                    rsp_valid  <= 1'b1;
                    rsp_data   <= cmd_reg.data;
                    rsp_flags  <= '0;
                    state_reg  <= RESP;
                end

                SYNC: begin
                    fpu_enable <= 1'b1;
                    fpu_ld     <= 1'b1;
                    fpu_addr1  <= cmd_reg.src1;
                    fpu_addr2  <= cmd_reg.src2;
                    fpu_opcode <= cmd_reg.op;
                    fpu_round  <= cmd_reg.round;
                    state_reg  <= LOAD;
                end

                LOAD: begin
                    fpu_ld    <= 1'b0;
                    fpu_addr3 <= cmd_reg.dst;
                    wd_reg    <= WD_W'(1);
                    state_reg <= EXEC;
                end

                EXEC: begin
                    // done on the final watchdog cycle still counts as a completion.
                    if (fpu_done) begin
                        rsp_data   <= fpu_out;
                        rsp_flags  <= {1'b0, fpu_ov, fpu_un, fpu_inv, fpu_inexact,
                                       fpu_div_zero, fpu_less, fpu_eq, fpu_great};
                        rsp_valid  <= 1'b1;
                        fpu_ld     <= 1'b1;
                        state_reg  <= RESP;
                    end else if (wd_reg == WD_W'(TIMEOUT)) begin
                        rsp_data   <= '0;
                        rsp_flags  <= 9'(1) << FLG_TIMEOUT;
                        rsp_valid  <= 1'b1;
                        fpu_ld     <= 1'b1;
                        state_reg  <= RESP;
                    end else begin
                        wd_reg <= wd_reg + WD_W'(1);
                    end
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state_reg <= IDLE;
                    end
                end

                default: begin
                    state_reg  <= IDLE;
                    cmd_ready  <= 1'b1;
                    rsp_valid  <= 1'b0;
                    fpu_enable <= 1'b1;
                    fpu_ld     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_seq.sv
// Directed-vector bench for fpu_seq against a small behavioural fpu stub
// whose latency, result and flags are set per vector.
module tb_fpu_seq;
    import fpu_pkg::*;

    logic        clk = 1'b0;
    logic        rstp;
    logic        cmd_valid, cmd_ready, cmd_kind;
    logic [2:0]  cmd_op, cmd_round;
    logic [4:0]  cmd_src1, cmd_src2, cmd_dst;
    logic [31:0] cmd_data;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic [8:0]  rsp_flags;
    logic [31:0] fpu_inp;
    logic [4:0]  fpu_addr1, fpu_addr2, fpu_addr3;
    logic [2:0]  fpu_opcode, fpu_round;
    logic        fpu_enable, fpu_ld;
    logic [31:0] fpu_out;
    logic        fpu_done, fpu_ov, fpu_un, fpu_inv, fpu_inexact, fpu_div_zero;
    logic        fpu_less, fpu_eq, fpu_great;

    always #5 clk = ~clk;

    fpu_seq dut (
        .clk(clk), .rstp(rstp),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind),
        .cmd_op(cmd_op), .cmd_round(cmd_round), .cmd_src1(cmd_src1),
        .cmd_src2(cmd_src2), .cmd_dst(cmd_dst), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_flags(rsp_flags),
        .fpu_inp(fpu_inp), .fpu_addr1(fpu_addr1), .fpu_addr2(fpu_addr2),
        .fpu_addr3(fpu_addr3), .fpu_opcode(fpu_opcode), .fpu_round(fpu_round),
        .fpu_enable(fpu_enable), .fpu_ld(fpu_ld),
        .fpu_out(fpu_out), .fpu_done(fpu_done), .fpu_ov(fpu_ov), .fpu_un(fpu_un),
        .fpu_inv(fpu_inv), .fpu_inexact(fpu_inexact), .fpu_div_zero(fpu_div_zero),
        .fpu_less(fpu_less), .fpu_eq(fpu_eq), .fpu_great(fpu_great)
    );

    // fpu stub: SRAM write when enable=ld=0, done counter cleared outside EXEC,
    // result and flags only valid in the done cycle.
    logic [31:0] mem [0:31];
    logic [7:0]  exec_cnt = 8'd0;
    logic [31:0] stub_out   = '0;
    logic [7:0]  stub_flags = '0;
    int          stub_lat   = 1;
    bit          stub_stuck = 1'b0;

    always @(posedge clk) begin
        exec_cnt <= (fpu_enable && !fpu_ld) ? exec_cnt + 8'd1 : 8'd0;
        if (!fpu_enable && !fpu_ld)
            mem[fpu_addr1] <= fpu_inp;
        else if (fpu_done)
            mem[fpu_addr3] <= stub_out;
    end

    assign fpu_done = fpu_enable && !fpu_ld && !stub_stuck && (int'(exec_cnt) == stub_lat - 1);
    assign fpu_out  = fpu_done ? stub_out : 32'hDEAD_BEEF;
    assign {fpu_ov, fpu_un, fpu_inv, fpu_inexact, fpu_div_zero, fpu_less, fpu_eq, fpu_great}
        = fpu_done ? stub_flags : 8'hA5;

    typedef struct {
        bit          kind;
        logic [2:0]  op;
        logic [2:0]  rnd;
        logic [4:0]  s1, s2, d;
        logic [31:0] data;
        logic [31:0] sout;
        logic [7:0]  sflags;
        int          slat;
        bit          stuck;
        logic [31:0] exp_data;
        logic [8:0]  exp_flags;
        int          exp_lat;
    } vec_t;

    vec_t vecs [10];
    int   n_applied = 0;
    int   n_miss    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Drive one command from a negedge, follow it to its response, optionally
    // hold rsp_ready low for `hold` cycles, then complete the handshake.
    task automatic run_vec(input vec_t v, input int idx, input int hold);
        int  k;
        int  n_en0;
        bit  got;
        stub_out   = v.sout;
        stub_flags = v.sflags;
        stub_lat   = v.slat;
        stub_stuck = v.stuck;
        cmd_kind = v.kind; cmd_op = v.op; cmd_round = v.rnd;
        cmd_src1 = v.s1; cmd_src2 = v.s2; cmd_dst = v.d; cmd_data = v.data;
        cmd_valid = 1'b1;
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        n_en0 = 0; got = 1'b0; k = 0;
        while (!got && k < 200) begin
            @(negedge clk);
            k++;
            if (!fpu_enable) n_en0++;
            if (rsp_valid) begin
                got = 1'b1;
            end else if (k == 1 && v.kind) begin
                chk("store_pins", {fpu_enable, fpu_ld, 3'b0, fpu_addr1, fpu_inp[21:0]},
                    {2'b00, 3'b0, v.d, v.data[21:0]});
                chk("store_inp", fpu_inp, v.data);
            end else if (k == 1) begin
                chk("sync_pins", {22'd0, fpu_enable, fpu_ld, fpu_addr1, fpu_opcode},
                    {22'd0, 2'b00, 5'd31, v.op});
                chk("sync_inp_round", {fpu_inp[28:0], fpu_round}, {29'd0, v.rnd});
            end else if (k == 2 && !v.kind) begin
                chk("load_pins", {20'd0, fpu_enable, fpu_ld, fpu_addr1, fpu_addr2},
                    {20'd0, 2'b11, v.s1, v.s2});
            end else if (k == 3 && !v.kind) begin
                chk("exec_pins", {25'd0, fpu_enable, fpu_ld, fpu_addr3}, {25'd0, 2'b10, v.d});
            end
        end
        if (!got) begin
            chk("rsp_valid_seen", 32'd0, 32'd1);
        end else begin
            chk("latency", 32'(k), 32'(v.exp_lat));
            chk("rsp_data", rsp_data, v.exp_data);
            chk("rsp_flags", 32'(rsp_flags), 32'(v.exp_flags));
            chk("en0_cycles", 32'(n_en0), 32'd1);
            for (int h = 0; h <= hold; h++) begin
                chk("resp_state", {rsp_valid, cmd_ready, fpu_enable, fpu_ld, rsp_flags, rsp_data[18:0]},
                    {4'b1011, v.exp_flags, v.exp_data[18:0]});
                if (h < hold) @(negedge clk);
            end
            rsp_ready = 1'b1;
            @(posedge clk);
            #1 rsp_ready = 1'b0;
            @(negedge clk);
            chk("post_handshake", {30'd0, rsp_valid, cmd_ready}, 32'b01);
        end
        $display("vec %0d kind=%0d op=%0d dst=%0d lat=%0d rsp_data=0x%08h flags=0x%03h",
                 idx, v.kind, v.op, v.d, k, rsp_data, rsp_flags);
    endtask

    initial begin
        bit saw_rsp;
        for (int i = 0; i < 32; i++) mem[i] = 32'd0;
        //            kind op    rnd   s1    s2    d      data          sout          sflags slat stuck exp_data      exp_flags lat
        vecs[0] = '{1'b1, 3'd0, 3'd0, 5'd0, 5'd0, 5'd2,  32'h3F800000, 32'h0,        8'h00, 1,  1'b0, 32'h3F800000, 9'h000, 2};
        vecs[1] = '{1'b1, 3'd0, 3'd0, 5'd0, 5'd0, 5'd3,  32'h40000000, 32'h0,        8'h00, 1,  1'b0, 32'h40000000, 9'h000, 2};
        vecs[2] = '{1'b0, 3'd0, 3'd0, 5'd2, 5'd3, 5'd4,  32'h0,        32'h40400000, 8'h00, 2,  1'b0, 32'h40400000, 9'h000, 5};
        vecs[3] = '{1'b0, 3'd1, 3'd2, 5'd2, 5'd3, 5'd5,  32'h0,        32'h40000000, 8'h00, 2,  1'b0, 32'h40000000, 9'h000, 5};
        vecs[4] = '{1'b0, 3'd2, 3'd1, 5'd2, 5'd6, 5'd7,  32'h0,        32'h7F800000, 8'h08, 7,  1'b0, 32'h7F800000, 9'h008, 10};
        vecs[5] = '{1'b0, 3'd3, 3'd3, 5'd3, 5'd0, 5'd8,  32'h0,        32'h3FB504F3, 8'h10, 7,  1'b0, 32'h3FB504F3, 9'h010, 10};
        vecs[6] = '{1'b0, 3'd4, 3'd0, 5'd2, 5'd3, 5'd9,  32'h0,        32'h0,        8'h04, 1,  1'b0, 32'h0,        9'h004, 4};
        vecs[7] = '{1'b0, 3'd4, 3'd0, 5'd3, 5'd3, 5'd9,  32'h0,        32'h0,        8'hE2, 1,  1'b0, 32'h0,        9'h0E2, 4};
        vecs[8] = '{1'b0, 3'd0, 3'd0, 5'd2, 5'd3, 5'd12, 32'h0,        32'h12345678, 8'h00, 64, 1'b0, 32'h12345678, 9'h000, 67};
        vecs[9] = '{1'b0, 3'd0, 3'd0, 5'd2, 5'd3, 5'd10, 32'h0,        32'h55555555, 8'h00, 1,  1'b1, 32'h0,        9'h100, 67};

        rstp = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_kind = 1'b0; cmd_op = '0; cmd_round = '0;
        cmd_src1 = '0; cmd_src2 = '0; cmd_dst = '0; cmd_data = '0;
        repeat (2) @(negedge clk);
        rstp = 1'b1;
        @(negedge clk);
        chk("reset_ctrl", {28'd0, fpu_enable, fpu_ld, cmd_ready, rsp_valid}, 32'b1110);
        chk("reset_addr", {14'd0, fpu_addr1, fpu_addr2, fpu_addr3, fpu_opcode}, 32'd0);
        chk("reset_data", rsp_data | fpu_inp | 32'(rsp_flags), 32'd0);

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], i, 0);
            if (i == 2) begin
                chk("mem4_sum", mem[4], 32'h40400000);
                chk("mem2_kept", mem[2], 32'h3F800000);
                chk("mem3_kept", mem[3], 32'h40000000);
            end
        end
        chk("timeout_no_write", mem[10], 32'd0);
        chk("cmp_wrote_dst", mem[9], 32'd0);

        // Backpressure: response must hold for 5 cycles with rsp_ready low.
        vecs[0].d = 5'd11; vecs[0].data = 32'hCAFEF00D; vecs[0].exp_data = 32'hCAFEF00D;
        run_vec(vecs[0], 10, 5);
        chk("mem11_store", mem[11], 32'hCAFEF00D);

        // Reset pulse in the middle of a divide: immediate abort, no response.
        stub_out = 32'h7F800000; stub_flags = 8'h08; stub_lat = 7; stub_stuck = 1'b0;
        cmd_kind = 1'b0; cmd_op = 3'd2; cmd_round = 3'd1;
        cmd_src1 = 5'd2; cmd_src2 = 5'd6; cmd_dst = 5'd13; cmd_data = '0;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_reset_exec", {30'd0, fpu_enable, fpu_ld}, 32'b10);
        rstp = 1'b0;
        #1;
        chk("midreset_ctrl", {28'd0, fpu_enable, fpu_ld, cmd_ready, rsp_valid}, 32'b1110);
        chk("midreset_addr", {14'd0, fpu_addr1, fpu_addr2, fpu_addr3, fpu_opcode}, 32'd0);
        @(negedge clk);
        rstp = 1'b1;
        saw_rsp = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid) saw_rsp = 1'b1;
        end
        chk("no_rsp_after_reset", 32'(saw_rsp), 32'd0);
        chk("abort_no_write", mem[13], 32'd0);
        $display("reset abort sequence done, cmd_ready=%0d", cmd_ready);

        vecs[1].d = 5'd14; vecs[1].data = 32'h0BADF00D; vecs[1].exp_data = 32'h0BADF00D;
        run_vec(vecs[1], 11, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang want finish");
        $fatal(1, "bench time limit");
    end

endmodule
